// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares one single-port data memory (async read, negedge write)
// between port A (CPU load/store) and port B (debug loader / DMA) using req/ack
// handshakes, round-robin arbitration, one ACCESS cycle then one RESP cycle.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN -- port A always wins a tie.
module mem_data_arbiter #(
   parameter int unsigned p_DATA_MEM_SIZE = 1024,
   parameter int unsigned p_WORD_LEN      = 16,
   parameter int unsigned p_ADDR_LEN      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [p_ADDR_LEN-1:0] a_addr,
   input  logic [p_WORD_LEN-1:0] a_wdata,
   output logic                  a_ack,
   output logic [p_WORD_LEN-1:0] a_rdata,
   output logic                  a_err,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [p_ADDR_LEN-1:0] b_addr,
   input  logic [p_WORD_LEN-1:0] b_wdata,
   output logic                  b_ack,
   output logic [p_WORD_LEN-1:0] b_rdata,
   output logic                  b_err,
   output logic [p_ADDR_LEN-1:0] mem_address,
   output logic [p_WORD_LEN-1:0] mem_dataIn,
   output logic                  mem_writeEn,
   input  logic [p_WORD_LEN-1:0] mem_dataOut,
   output logic                  busy
);

   localparam int unsigned IDX_LEN = $clog2(p_DATA_MEM_SIZE);
   localparam logic        OWN_A   = 1'b0;
   localparam logic        OWN_B   = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  owner_q;
   logic                  owner_d;
   logic                  last_q;
   logic                  last_d;
   logic [p_WORD_LEN-1:0] rdata_q;
   logic                  err_q;

   logic [p_ADDR_LEN-1:0] own_addr;
   logic [p_WORD_LEN-1:0] own_wdata;
   logic                  own_we;
   logic                  own_err;

   // Select the granted requester's transaction fields
   assign own_addr  = (owner_q == OWN_B) ? b_addr  : a_addr;
   assign own_wdata = (owner_q == OWN_B) ? b_wdata : a_wdata;
   assign own_we    = (owner_q == OWN_B) ? b_we    : a_we;
   // Any address bit above the implemented index range marks the access out of range
   assign own_err   = ((own_addr >> IDX_LEN) != '0);

   // State, owner and last-grant registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= OWN_A;
         last_q  <= OWN_B;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Capture read data and range flag at the end of the ACCESS cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_q == S_ACCESS) begin
         rdata_q <= (!own_we && !own_err) ? mem_dataOut : '0;
         err_q   <= own_err;
      end
   end

   // Next-state and arbitration decision
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               if (a_req && b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                  owner_d = OWN_A;
`else
                  owner_d = ~last_q;
`endif
               end else begin
                  owner_d = b_req ? OWN_B : OWN_A;
               end
               last_d  = owner_d;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Memory drive during ACCESS, ack/response decode during RESP
   always_comb begin
      mem_address = '0;
      mem_dataIn  = '0;
      mem_writeEn = 1'b0;
      a_ack       = 1'b0;
      a_err       = 1'b0;
      a_rdata     = '0;
      b_ack       = 1'b0;
      b_err       = 1'b0;
      b_rdata     = '0;
      busy        = (state_q != S_IDLE);
      case (state_q)
         S_ACCESS: begin
            mem_address = own_addr;
            mem_dataIn  = own_wdata;
            // rst blocks the negedge commit so a reset mid-access leaves memory intact
            mem_writeEn = own_we & ~own_err & ~rst;
         end
         S_RESP: begin
            if (!rst) begin
               if (owner_q == OWN_A) begin
                  a_ack   = 1'b1;
                  a_rdata = rdata_q;
                  a_err   = err_q;
               end else begin
                  b_ack   = 1'b1;
                  b_rdata = rdata_q;
                  b_err   = err_q;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: directed vector table, hand sequences for reset/arbitration
// corners, and a randomized run scored against a transaction-level model.
module tb_mem_data_arbiter;

   localparam int unsigned MEM_WORDS = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_err, b_ack, b_err;
   logic [15:0] a_rdata, b_rdata;
   logic [15:0] mem_address, mem_dataIn, mem_dataOut;
   logic        mem_writeEn;
   logic        busy;
   logic        ram_load;

   logic [15:0] ram [0:MEM_WORDS-1];
   logic [15:0] ref_mem [0:MEM_WORDS-1];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_data_arbiter dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
      .mem_address(mem_address), .mem_dataIn(mem_dataIn),
      .mem_writeEn(mem_writeEn), .mem_dataOut(mem_dataOut), .busy(busy)
   );

   function automatic logic [15:0] init_word(input int i);
      return (i == 16) ? 16'h5555 : 16'(i * 37 + 11);
   endfunction

   // Attached data memory: asynchronous read, write committed on negedge
   always @(negedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
      end else if (mem_writeEn) begin
         ram[mem_address[9:0]] <= mem_dataIn;
      end
   end
   assign mem_dataOut = ram[mem_address[9:0]];

   typedef struct {
      logic        a_req;  logic a_we; logic [15:0] a_addr; logic [15:0] a_wdata;
      logic        b_req;  logic b_we; logic [15:0] b_addr; logic [15:0] b_wdata;
      logic        e_busy; logic e_we; logic [15:0] e_maddr; logic [15:0] e_mdin;
      logic        e_aack; logic e_aerr; logic [15:0] e_ardata;
      logic        e_back; logic e_berr; logic [15:0] e_brdata;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset(input logic reload);
      rst = 1'b1;
      ram_load = reload;
      drive_idle();
      repeat (2) tick();
      rst = 1'b0;
      ram_load = 1'b0;
   endtask

   task automatic gen_req(output logic we, output logic [15:0] addr, output logic [15:0] wd);
      int r;
      we = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r < 8) addr = 16'($urandom_range(0, 31));
      else begin
         case ($urandom_range(0, 3))
            0:       addr = 16'h0400;
            1:       addr = 16'h8000;
            2:       addr = 16'hFFFF;
            default: addr = 16'h03FF;
         endcase
      end
   endtask

   // Transaction-level reference state for the randomized run
   int          ph;
   logic        m_own;    // 0 = A, 1 = B
   logic        m_last;
   logic [15:0] e_rd;
   logic        e_err;

   initial begin
      vec_t        v;
      logic [15:0] addr, wd;
      logic        we, exp_we;
      logic        ea, eb;

      // Directed table: inputs applied before an edge, outputs expected after it
      tbl[0]  = '{1,1,16'h0005,16'hBEEF, 0,0,16'h0,16'h0,    1,1,16'h0005,16'hBEEF, 0,0,16'h0,      0,0,16'h0};
      tbl[1]  = '{1,1,16'h0005,16'hBEEF, 0,0,16'h0,16'h0,    1,0,16'h0,16'h0,       1,0,16'h0,      0,0,16'h0};
      tbl[2]  = '{0,0,16'h0,16'h0,       1,0,16'h0005,16'h0, 0,0,16'h0,16'h0,       0,0,16'h0,      0,0,16'h0};
      tbl[3]  = '{0,0,16'h0,16'h0,       1,0,16'h0005,16'h0, 1,0,16'h0005,16'h0,    0,0,16'h0,      0,0,16'h0};
      tbl[4]  = '{0,0,16'h0,16'h0,       1,0,16'h0005,16'h0, 1,0,16'h0,16'h0,       0,0,16'h0,      1,0,16'hBEEF};
      tbl[5]  = '{0,0,16'h0,16'h0,       1,1,16'h0400,16'h1234, 0,0,16'h0,16'h0,    0,0,16'h0,      0,0,16'h0};
      tbl[6]  = '{0,0,16'h0,16'h0,       1,1,16'h0400,16'h1234, 1,0,16'h0400,16'h1234, 0,0,16'h0,   0,0,16'h0};
      tbl[7]  = '{0,0,16'h0,16'h0,       1,1,16'h0400,16'h1234, 1,0,16'h0,16'h0,    0,0,16'h0,      1,1,16'h0};
      tbl[8]  = '{0,0,16'h0,16'h0,       0,0,16'h0,16'h0,    0,0,16'h0,16'h0,       0,0,16'h0,      0,0,16'h0};
      tbl[9]  = '{1,0,16'h0003,16'h0,    0,0,16'h0,16'h0,    1,0,16'h0003,16'h0,    0,0,16'h0,      0,0,16'h0};
      tbl[10] = '{0,0,16'h0003,16'h0,    0,0,16'h0,16'h0,    1,0,16'h0,16'h0,       1,0,16'h007A,   0,0,16'h0};
      tbl[11] = '{0,0,16'h0,16'h0,       0,0,16'h0,16'h0,    0,0,16'h0,16'h0,       0,0,16'h0,      0,0,16'h0};

      do_reset(1'b1);
      chk("reset busy",  16'(busy), 16'h0);
      chk("reset a_ack", 16'(a_ack), 16'h0);
      chk("reset b_ack", 16'(b_ack), 16'h0);
      chk("reset a_err", 16'(a_err), 16'h0);
      chk("reset we",    16'(mem_writeEn), 16'h0);
      chk("reset addr",  mem_address, 16'h0);
      chk("reset din",   mem_dataIn, 16'h0);
      chk("reset a_rdata", a_rdata, 16'h0);

      for (int i = 0; i < 12; i++) begin
         v = tbl[i];
         a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
         b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
         tick();
         chk($sformatf("row%0d busy", i),    16'(busy),        16'(v.e_busy));
         chk($sformatf("row%0d we", i),      16'(mem_writeEn), 16'(v.e_we));
         chk($sformatf("row%0d maddr", i),   mem_address,      v.e_maddr);
         chk($sformatf("row%0d mdin", i),    mem_dataIn,       v.e_mdin);
         chk($sformatf("row%0d a_ack", i),   16'(a_ack),       16'(v.e_aack));
         chk($sformatf("row%0d a_err", i),   16'(a_err),       16'(v.e_aerr));
         chk($sformatf("row%0d a_rdata", i), a_rdata,          v.e_ardata);
         chk($sformatf("row%0d b_ack", i),   16'(b_ack),       16'(v.e_back));
         chk($sformatf("row%0d b_err", i),   16'(b_err),       16'(v.e_berr));
         chk($sformatf("row%0d b_rdata", i), b_rdata,          v.e_brdata);
      end
      chk("oor word0 intact", ram[0], init_word(0));
      chk("write landed",     ram[5], 16'hBEEF);

      // Reset during ACCESS of a write: no commit, no ack
      a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'hAAAA;
      tick();
      chk("rstacc we before rst", 16'(mem_writeEn), 16'h1);
      rst = 1'b1;
      #1;
      chk("rstacc we with rst", 16'(mem_writeEn), 16'h0);
      tick();
      chk("rstacc a_ack", 16'(a_ack), 16'h0);
      chk("rstacc busy",  16'(busy),  16'h0);
      rst = 1'b0;
      a_we = 1'b0;
      repeat (2) tick();
      chk("rstacc readback ack",   16'(a_ack), 16'h1);
      chk("rstacc readback rdata", a_rdata, 16'h5555);
      chk("rstacc ram",            ram[16], 16'h5555);
      a_req = 1'b0;
      tick();

      // Reset during RESP suppresses the ack
      a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0002;
      repeat (2) tick();
      chk("rstresp ack before rst", 16'(a_ack), 16'h1);
      rst = 1'b1;
      #1;
      chk("rstresp ack with rst", 16'(a_ack), 16'h0);
      a_req = 1'b0;
      tick();
      rst = 1'b0;

      // Both ports requesting continuously
      do_reset(1'b0);
      a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0001;
      b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0002;
      for (int k = 1; k <= 21; k++) begin
         tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
         ea = (k % 3 == 2);
         eb = 1'b0;
`else
         ea = (k % 6 == 2);
         eb = (k % 6 == 5);
`endif
         chk($sformatf("tie k%0d a_ack", k), 16'(a_ack), 16'(ea));
         chk($sformatf("tie k%0d b_ack", k), 16'(b_ack), 16'(eb));
         if (ea) chk($sformatf("tie k%0d a_rdata", k), a_rdata, init_word(1));
         if (eb) chk($sformatf("tie k%0d b_rdata", k), b_rdata, init_word(2));
      end
      drive_idle();
      repeat (3) tick();

      // Randomized traffic against the reference model
      do_reset(1'b1);
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
      ph = 0; m_own = 1'b0; m_last = 1'b1; e_rd = '0; e_err = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         tick();
         case (ph)
            0: if (a_req || b_req) begin
                  if (a_req && b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                     m_own = 1'b0;
`else
                     m_own = !m_last;
`endif
                  end else begin
                     m_own = b_req;
                  end
                  m_last = m_own;
                  ph = 1;
               end
            1: ph = 2;
            default: ph = 0;
         endcase

         exp_we = 1'b0;
         if (ph == 1) begin
            addr  = m_own ? b_addr  : a_addr;
            wd    = m_own ? b_wdata : a_wdata;
            we    = m_own ? b_we    : a_we;
            e_err = (int'(addr) >= MEM_WORDS);
            exp_we = we && !e_err;
            e_rd  = (!we && !e_err) ? ref_mem[addr[9:0]] : 16'h0;
            if (exp_we) ref_mem[addr[9:0]] = wd;
            chk($sformatf("rnd c%0d maddr", c), mem_address, addr);
            if (exp_we) chk($sformatf("rnd c%0d mdin", c), mem_dataIn, wd);
         end
         ea = (ph == 2) && !m_own;
         eb = (ph == 2) &&  m_own;
         chk($sformatf("rnd c%0d busy", c),  16'(busy),        16'(ph != 0));
         chk($sformatf("rnd c%0d we", c),    16'(mem_writeEn), 16'(exp_we));
         chk($sformatf("rnd c%0d a_ack", c), 16'(a_ack),       16'(ea));
         chk($sformatf("rnd c%0d b_ack", c), 16'(b_ack),       16'(eb));
         if (ph == 2) begin
            chk($sformatf("rnd c%0d own rdata", c), m_own ? b_rdata : a_rdata, e_rd);
            chk($sformatf("rnd c%0d own err", c),   16'(m_own ? b_err : a_err), 16'(e_err));
            chk($sformatf("rnd c%0d other rdata", c), m_own ? a_rdata : b_rdata, 16'h0);
         end

         // Requesters hold until their ack, then re-request or go quiet
         if (ea || (!a_req && $urandom_range(0, 2) == 0)) begin
            a_req = ea ? 1'($urandom_range(0, 1)) : 1'b1;
            gen_req(we, addr, wd);
            a_we = we; a_addr = addr; a_wdata = wd;
         end
         if (eb || (!b_req && $urandom_range(0, 2) == 0)) begin
            b_req = eb ? 1'($urandom_range(0, 1)) : 1'b1;
            gen_req(we, addr, wd);
            b_we = we; b_addr = addr; b_wdata = wd;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
Shares the single-port data memory (asynchronous read, negedge write) between two requesters: port A (CPU load/store path) and port B (debug loader / DMA).
- Each request uses a req/ack handshake.
- Arbitration is round-robin by default.
- Each granted access takes one ACCESS cycle, then one response cycle.
- Sits between the requesters and the mem_data instance, and drives all of that instance's inputs.

Parameters:
p_DATA_MEM_SIZE  1024  words implemented in the attached memory; used for the out-of-range check
p_WORD_LEN       16    data word width
p_ADDR_LEN       16    address width

Ports:
clk          input   1           clock; all state changes on posedge
rst          input   1           synchronous, active-high reset
a_req        input   1           port A request; held with a_we/a_addr/a_wdata stable until a_ack
a_we         input   1           port A write (1) / read (0)
a_addr       input   p_ADDR_LEN  port A address
a_wdata      input   p_WORD_LEN  port A write data
a_ack        output  1           port A one-cycle completion pulse
a_rdata      output  p_WORD_LEN  port A read data, valid while a_ack=1
a_err        output  1           port A out-of-range flag, valid while a_ack=1
b_*          (same six signals for port B)
mem_address  output  p_ADDR_LEN  to memory address
mem_dataIn   output  p_WORD_LEN  to memory write data
mem_writeEn  output  1           to memory write enable
mem_dataOut  input   p_WORD_LEN  from memory asynchronous read data
busy         output  1           high in ACCESS or RESP

Behaviour:
- FSM has three states: IDLE, ACCESS, RESP. Registers: state, owner (A/B), last_grant, rdata_q, err_q.
- Reset values:
  - state=IDLE, owner=A, last_grant=B (so A wins the first tie).
  - rdata_q=0, err_q=0.
  - All acks and errs 0; busy 0; mem_writeEn 0; mem_address and mem_dataIn 0.
- IDLE:
  - No req: stay in IDLE.
  - One req: owner=that port.
  - Both reqs: owner=the port not equal to last_grant.
  - With any req: last_grant=owner, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address, mem_dataIn and the we/err logic are driven combinationally from the owner's inputs.
  - err = owner address bits [p_ADDR_LEN-1:$clog2(p_DATA_MEM_SIZE)] nonzero.
  - mem_writeEn = owner_we & ~err & ~rst. The memory commits at the following negedge.
  - At posedge: rdata_q = (read & ~err) ? mem_dataOut : 0; err_q = err. Go to RESP.
- RESP (exactly one cycle):
  - Owner's ack=1, its rdata=rdata_q, its err=err_q.
  - Non-owner ack/err=0; its rdata holds 0.
  - Memory outputs return to 0.
  - Always go to IDLE. A req seen in RESP is not arbitrated until IDLE.
- Timing:
  - Latency is 2 cycles from a req sampled in IDLE to ack.
  - Throughput is one access per 3 cycles.
  - A req arriving while busy waits; it is never dropped.
- Outside ACCESS: mem_address=0, mem_dataIn=0, mem_writeEn=0.
- Write-data timing: the write at the negedge inside ACCESS uses the values held by the requester. Requesters must not change inputs before ack.
- Reset mid-operation: rst high during ACCESS forces mem_writeEn=0 in the same cycle, so no partial write occurs. The next posedge returns to IDLE with no ack. rst during RESP suppresses that ack.
- Requester drops req before ack (protocol violation): the access still completes; ack is still pulsed.
- Width: addresses are passed through unmodified. No arithmetic beyond the range compare.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: on a tie in IDLE, A always wins. last_grant is still updated but ignored. B can starve while A requests back-to-back.
- Undefined: round-robin as above.

Test Plan:
- Reset then single A write: a_req=1, a_we=1, a_addr=0x0005, a_wdata=0xBEEF -> mem_writeEn=1 only in cycle 1; a_ack in cycle 2 with a_err=0. A following B read of 0x0005 -> b_rdata=0xBEEF with b_ack.
- Simultaneous reqs held continuously, A reads 0x0001 and B reads 0x0002 -> grants alternate A,B,A,B (ack pulses 3 cycles apart). With MEM_ARB_FIXED_PRIO_EN, a_req held permanently -> b_ack never asserts during 20 cycles.
- Out of range: b_addr=0x0400, b_we=1, b_wdata=0x1234 (p_DATA_MEM_SIZE=1024) -> mem_writeEn stays 0; b_ack with b_err=1 and b_rdata=0; word 0x0000 is unchanged.
- Reset during ACCESS of an A write to 0x0010 (wdata 0xAAAA; word previously 0x5555) -> no a_ack; mem_writeEn=0 that cycle; a later read of 0x0010 returns 0x5555.
- Late req: b_req asserted during A's RESP cycle -> B is granted in the next IDLE; b_ack arrives exactly 3 cycles after a_ack; busy=0 only in the IDLE cycle between them.
